// File: rtl/priv_1_12_clint_timer.sv
// ============================================================================
// priv_1_12_clint_timer
// ----------------------------------------------------------------------------
// Machine-level timer and software-interrupt source, CLINT style, for the
// v1.12 privilege block. It sits on the core's memory-mapped peripheral bus
// and holds msip, mtimecmp and mtime. It also drives the interrupt-source and
// interrupt-clear inputs of the interrupt/exception handler.
//
// Register map (byte offset from BASE_ADDR; only addr[15:0] is decoded):
//   0x0000  msip            bit0 RW, bits 31:1 read as zero
//   0x4000  mtimecmp[31:0]
//   0x4004  mtimecmp[63:32]
//   0xBFF8  mtime[31:0]
//   0xBFFC  mtime[63:32]
//
// Parameters:
//   PRESCALE   core clock cycles per mtime increment (must be >= 1)
//   BASE_ADDR  bus base address (informational; decode is offset-only)
//
// Ports:
//   CLK                core clock
//   RST                asynchronous active-high reset
//   req                bus request valid (single cycle, may repeat every cycle)
//   wen                1 = write, 0 = read (qualified by req)
//   addr               byte address, word aligned
//   wdata              write data
//   ack                response valid, exactly one cycle after req
//   err                valid with ack: unmapped offset or misaligned address
//   rdata              read data, valid with ack (zero otherwise)
//   timer_int_m        machine timer interrupt pending level
//   soft_int_m         machine software interrupt pending level
//   clear_timer_int_m  one-cycle pulse coinciding with timer_int_m falling
//   clear_soft_int_m   one-cycle pulse coinciding with soft_int_m falling
//
// Optional feature (macro CLINT_MTIME_SNAPSHOT_EN):
//   When defined, a read of mtime[31:0] latches mtime[63:32] into a snapshot
//   register; a following read of mtime[63:32] returns that snapshot, giving
//   a tear-free 64-bit read. Any write to mtime invalidates the snapshot so
//   the next hi read returns the live value. When undefined, the hi read is
//   always live and no snapshot register exists.
// ============================================================================
module priv_1_12_clint_timer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        timer_int_m,
    output logic        soft_int_m,
    output logic        clear_timer_int_m,
    output logic        clear_soft_int_m
);

    // Register offsets within the 64 KiB window.
    localparam logic [15:0] OFF_MSIP    = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
    localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

    // The prescale counter needs at least one bit even when PRESCALE is 1,
    // in which case it simply sits at zero and every cycle is a tick.
    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    // Architectural state.
    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             msip;
    logic [CNT_W-1:0] presc_cnt;

    // Next-state values.
    logic [63:0]      mtime_next;
    logic [63:0]      mtimecmp_next;
    logic             msip_next;
    logic [CNT_W-1:0] presc_cnt_next;
    logic             timer_level_next;

    // Decode results.
    logic [15:0] offset;
    logic        aligned;
    logic        sel_msip;
    logic        sel_cmp_lo;
    logic        sel_cmp_hi;
    logic        sel_time_lo;
    logic        sel_time_hi;
    logic        hit;
    logic        rd_en;
    logic        wr_en;
    logic        wr_time;
    logic        tick;

    // Read path.
    logic [31:0] rd_value;
    logic [31:0] time_hi_view;

    // The upper address bits and the base address do not take part in the
    // decode; the bus fabric has already steered the request here.
    logic unused_decode_bits;
    assign unused_decode_bits = ^{addr[31:16], BASE_ADDR};

    // Address decode. A misaligned address never selects any register, so it
    // falls into the same error response as an unmapped offset.
    always_comb begin
        offset      = addr[15:0];
        aligned     = (addr[1:0] == 2'b00);
        sel_msip    = req && aligned && (offset == OFF_MSIP);
        sel_cmp_lo  = req && aligned && (offset == OFF_CMP_LO);
        sel_cmp_hi  = req && aligned && (offset == OFF_CMP_HI);
        sel_time_lo = req && aligned && (offset == OFF_TIME_LO);
        sel_time_hi = req && aligned && (offset == OFF_TIME_HI);
        hit         = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;
        rd_en       = hit && !wen;
        wr_en       = hit && wen;
        wr_time     = wr_en && (sel_time_lo || sel_time_hi);
    end

    // Prescaler tick: the counter walks 0..PRESCALE-1 and mtime advances on
    // the cycle it sits at PRESCALE-1.
    assign tick = (presc_cnt == CNT_MAX);

    // Next-state computation for the timer, compare and msip registers.
    // A write to one half of mtime wins over the increment for that half and
    // freezes the other half at its current value, so a software update never
    // sees a stray carry. Any mtime write also restarts the prescale period
    // so the freshly written value gets a full period before advancing.
    always_comb begin
        mtime_next     = tick ? (mtime + 64'd1) : mtime;
        mtimecmp_next  = mtimecmp;
        msip_next      = msip;
        presc_cnt_next = tick ? '0 : (presc_cnt + CNT_W'(1));

        if (wr_en) begin
            if (sel_time_lo) begin
                mtime_next = {mtime[63:32], wdata};
            end
            if (sel_time_hi) begin
                mtime_next = {wdata, mtime[31:0]};
            end
            if (sel_cmp_lo) begin
                mtimecmp_next[31:0] = wdata;
            end
            if (sel_cmp_hi) begin
                mtimecmp_next[63:32] = wdata;
            end
            if (sel_msip) begin
                msip_next = wdata[0];
            end
        end

        if (wr_time) begin
            presc_cnt_next = '0;
        end

        timer_level_next = (mtime_next >= mtimecmp_next);
    end

`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [31:0] snap_hi;
    logic        snap_valid;

    // Snapshot of the upper mtime half, captured on every lo read. A write to
    // either half of mtime makes the snapshot stale, so it is dropped and the
    // next hi read falls back to the live value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            snap_hi    <= '0;
            snap_valid <= 1'b0;
        end else begin
            if (rd_en && sel_time_lo) begin
                snap_hi    <= mtime[63:32];
                snap_valid <= 1'b1;
            end else if (wr_time) begin
                snap_valid <= 1'b0;
            end
        end
    end

    assign time_hi_view = snap_valid ? snap_hi : mtime[63:32];
`else
    assign time_hi_view = mtime[63:32];
`endif

    // Read multiplexer. Reads observe the state as it stands at the request
    // edge, i.e. before any write or increment taking effect on that edge.
    always_comb begin
        rd_value = '0;
        case (offset)
            OFF_MSIP:    rd_value = {31'd0, msip};
            OFF_CMP_LO:  rd_value = mtimecmp[31:0];
            OFF_CMP_HI:  rd_value = mtimecmp[63:32];
            OFF_TIME_LO: rd_value = mtime[31:0];
            OFF_TIME_HI: rd_value = time_hi_view;
            default:     rd_value = '0;
        endcase
    end

    // Architectural registers and prescaler.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            msip      <= 1'b0;
            presc_cnt <= '0;
        end else begin
            mtime     <= mtime_next;
            mtimecmp  <= mtimecmp_next;
            msip      <= msip_next;
            presc_cnt <= presc_cnt_next;
        end
    end

    // Bus response. Every request gets exactly one ack on the following
    // cycle; err and rdata are forced to zero whenever there is no ack so the
    // bus can OR responses from several slaves. A reset during the ack cycle
    // clears it, and since req is not remembered nothing is replayed later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= req;
            err   <= req && !hit;
            rdata <= rd_en ? rd_value : '0;
        end
    end

    // Interrupt levels and clear pulses. Both levels are computed from the
    // post-update state so a write to mtimecmp or msip is reflected on the
    // very next cycle. The clear pulses fire on the same cycle the level
    // drops, so a write that leaves msip unchanged never produces one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer_int_m       <= 1'b0;
            soft_int_m        <= 1'b0;
            clear_timer_int_m <= 1'b0;
            clear_soft_int_m  <= 1'b0;
        end else begin
            timer_int_m       <= timer_level_next;
            soft_int_m        <= msip_next;
            clear_timer_int_m <= timer_int_m && !timer_level_next;
            clear_soft_int_m  <= soft_int_m && !msip_next;
        end
    end

endmodule

// File: tb/tb_priv_1_12_clint_timer.sv
// ============================================================================
// tb_priv_1_12_clint_timer
// ----------------------------------------------------------------------------
// Self-checking bench for priv_1_12_clint_timer. Two instances share one
// clock and reset: a PRESCALE=1 instance that carries all bus traffic, and a
// PRESCALE=4 instance that is only read once to confirm the tick rate.
// Expected values come from a behavioural model that treats mtime as a
// 64-bit number advanced by one per cycle, with the register map applied
// as plain reads and writes of that number. Honours CLINT_MTIME_SNAPSHOT_EN.
// ============================================================================
module tb_priv_1_12_clint_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [15:0] A_MSIP    = 16'h0000;
    localparam logic [15:0] A_CMP_LO  = 16'h4000;
    localparam logic [15:0] A_CMP_HI  = 16'h4004;
    localparam logic [15:0] A_TIME_LO = 16'hBFF8;
    localparam logic [15:0] A_TIME_HI = 16'hBFFC;

`ifdef CLINT_MTIME_SNAPSHOT_EN
    localparam bit          SNAP_ON     = 1'b1;
    localparam logic [31:0] SNAP_HI_EXP = 32'd5;
`else
    localparam bit          SNAP_ON     = 1'b0;
    localparam logic [31:0] SNAP_HI_EXP = 32'd6;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        req, wen;
    logic [31:0] addr, wdata;
    logic        ack, err;
    logic [31:0] rdata;
    logic        timer_int_m, soft_int_m, clear_timer_int_m, clear_soft_int_m;

    logic        p4_req, p4_wen;
    logic [31:0] p4_addr, p4_wdata;
    logic        p4_ack, p4_err;
    logic [31:0] p4_rdata;
    logic        p4_tint, p4_sint, p4_ctint, p4_csint;

    int checks;
    int errors;

    // Behavioural model state, as seen after the most recent edge.
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_tint;
    logic        m_sint;
    logic [31:0] m_snap;
    logic        m_snap_valid;

    int unsigned edge_cnt;

    priv_1_12_clint_timer #(.PRESCALE(1), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST), .req(req), .wen(wen), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata),
        .timer_int_m(timer_int_m), .soft_int_m(soft_int_m),
        .clear_timer_int_m(clear_timer_int_m), .clear_soft_int_m(clear_soft_int_m)
    );

    priv_1_12_clint_timer #(.PRESCALE(4), .BASE_ADDR(BASE)) dut_p4 (
        .CLK(CLK), .RST(RST), .req(p4_req), .wen(p4_wen), .addr(p4_addr), .wdata(p4_wdata),
        .ack(p4_ack), .err(p4_err), .rdata(p4_rdata),
        .timer_int_m(p4_tint), .soft_int_m(p4_sint),
        .clear_timer_int_m(p4_ctint), .clear_soft_int_m(p4_csint)
    );

    // 10 ns core clock.
    always #5 CLK = ~CLK;

    // Count rising edges since reset release; used for the prescaler check.
    always @(posedge CLK or posedge RST) begin
        if (RST) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Model state immediately after reset.
    task automatic model_reset();
        m_time       = 64'd0;
        m_cmp        = {64{1'b1}};
        m_msip       = 1'b0;
        m_tint       = 1'b0;
        m_sint       = 1'b0;
        m_snap       = 32'd0;
        m_snap_valid = 1'b0;
    endtask

    // Advance one clock with the currently driven bus inputs, predicting the
    // response and interrupt outputs from the model and checking them at the
    // following falling edge.
    task automatic step();
        logic [63:0] nt, nc;
        logic        nm, nti, e_err, mapped;
        logic [31:0] e_rd, n_snap;
        logic        n_snap_v;
        logic [15:0] off;
        nt       = m_time + 64'd1;
        nc       = m_cmp;
        nm       = m_msip;
        e_err    = 1'b0;
        e_rd     = 32'd0;
        n_snap   = m_snap;
        n_snap_v = m_snap_valid;
        off      = addr[15:0];
        mapped   = (addr[1:0] == 2'b00) &&
                   (off == A_MSIP || off == A_CMP_LO || off == A_CMP_HI ||
                    off == A_TIME_LO || off == A_TIME_HI);
        if (req && !mapped) begin
            e_err = 1'b1;
        end else if (req && !wen) begin
            case (off)
                A_MSIP:    e_rd = {31'd0, m_msip};
                A_CMP_LO:  e_rd = m_cmp[31:0];
                A_CMP_HI:  e_rd = m_cmp[63:32];
                A_TIME_LO: begin
                    e_rd     = m_time[31:0];
                    n_snap   = m_time[63:32];
                    n_snap_v = 1'b1;
                end
                default:   e_rd = (SNAP_ON && m_snap_valid) ? m_snap : m_time[63:32];
            endcase
        end else if (req) begin
            case (off)
                A_MSIP:    nm = wdata[0];
                A_CMP_LO:  nc[31:0] = wdata;
                A_CMP_HI:  nc[63:32] = wdata;
                A_TIME_LO: begin
                    nt       = {m_time[63:32], wdata};
                    n_snap_v = 1'b0;
                end
                default: begin
                    nt       = {wdata, m_time[31:0]};
                    n_snap_v = 1'b0;
                end
            endcase
        end
        nti = (nt >= nc);
        @(negedge CLK);
        check_output("ack",        ack,               req);
        check_output("err",        err,               e_err);
        check_output("rdata",      rdata,             e_rd);
        check_output("timer_int",  timer_int_m,       nti);
        check_output("soft_int",   soft_int_m,        nm);
        check_output("clear_tint", clear_timer_int_m, m_tint & ~nti);
        check_output("clear_sint", clear_soft_int_m,  m_sint & ~nm);
        m_time       = nt;
        m_cmp        = nc;
        m_msip       = nm;
        m_tint       = nti;
        m_sint       = nm;
        m_snap       = n_snap;
        m_snap_valid = n_snap_v;
    endtask

    // Drive one bus cycle (or an idle cycle) and advance the clock.
    task automatic apply_stimulus(input logic r, input logic w,
                                  input logic [31:0] a, input logic [31:0] d);
        req   = r;
        wen   = w;
        addr  = a;
        wdata = d;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] p4_expect;
        logic [31:0] ra, rd;
        logic [15:0] pick;
        int          kind;

        checks = 0;
        errors = 0;
        req = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
        p4_req = 1'b0; p4_wen = 1'b0; p4_addr = '0; p4_wdata = '0;
        model_reset();

        // Reset state.
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check_output("rst_ack",    ack,               1'b0);
        check_output("rst_err",    err,               1'b0);
        check_output("rst_rdata",  rdata,             32'd0);
        check_output("rst_tint",   timer_int_m,       1'b0);
        check_output("rst_sint",   soft_int_m,        1'b0);
        check_output("rst_ctint",  clear_timer_int_m, 1'b0);
        check_output("rst_csint",  clear_soft_int_m,  1'b0);
        check_output("rst_p4_ack", p4_ack,            1'b0);
        RST = 1'b0;

        // Back-to-back reads straight out of reset.
        apply_stimulus(1'b1, 1'b0, BASE | A_TIME_LO, 32'd0);
        check_output("reset_mtime_lo", rdata, 32'd0);
        apply_stimulus(1'b1, 1'b0, BASE | A_CMP_HI, 32'd0);
        check_output("reset_cmp_hi", rdata, 32'hFFFF_FFFF);

        // Prescaler: let the PRESCALE=4 instance run, then read its mtime.
        idle(40);
        p4_req    = 1'b1;
        p4_wen    = 1'b0;
        p4_addr   = BASE | A_TIME_LO;
        p4_expect = edge_cnt / 4;
        idle(1);
        check_output("p4_ack",   p4_ack,   1'b1);
        check_output("p4_err",   p4_err,   1'b0);
        check_output("p4_mtime", p4_rdata, p4_expect);
        p4_req = 1'b0;

        // Timer interrupt rising at mtime == mtimecmp, then falling.
        apply_stimulus(1'b1, 1'b1, BASE | A_CMP_HI, 32'd0);
        apply_stimulus(1'b1, 1'b1, BASE | A_TIME_LO, 32'd0);
        apply_stimulus(1'b1, 1'b1, BASE | A_CMP_LO, 32'd20);
        idle(18);
        check_output("tint_before", timer_int_m, 1'b0);
        idle(1);
        check_output("tint_rise", timer_int_m, 1'b1);
        idle(5);
        apply_stimulus(1'b1, 1'b1, BASE | A_CMP_LO, 32'd1000);
        check_output("ctint_pulse", clear_timer_int_m, 1'b1);
        idle(1);
        check_output("ctint_one", clear_timer_int_m, 1'b0);

        // Software interrupt and its clear pulse.
        apply_stimulus(1'b1, 1'b1, BASE | A_MSIP, 32'd1);
        check_output("sint_set", soft_int_m, 1'b1);
        apply_stimulus(1'b1, 1'b1, BASE | A_MSIP, 32'd0);
        check_output("csint_pulse", clear_soft_int_m, 1'b1);
        idle(1);
        apply_stimulus(1'b1, 1'b1, BASE | A_MSIP, 32'hFFFF_FFFE);
        check_output("csint_none", clear_soft_int_m, 1'b0);

        // Carry from lo into hi.
        apply_stimulus(1'b1, 1'b1, BASE | A_TIME_HI, 32'd0);
        apply_stimulus(1'b1, 1'b1, BASE | A_TIME_LO, 32'hFFFF_FFFF);
        idle(1);
        apply_stimulus(1'b1, 1'b0, BASE | A_TIME_HI, 32'd0);
        check_output("carry_hi", rdata, 32'd1);
        apply_stimulus(1'b1, 1'b0, BASE | A_TIME_LO, 32'd0);

        // Write lo on an increment edge: the written value is what is held.
        apply_stimulus(1'b1, 1'b1, BASE | A_TIME_LO, 32'h1234_0000);
        apply_stimulus(1'b1, 1'b0, BASE | A_TIME_LO, 32'd0);
        check_output("wr_on_tick", rdata, 32'h1234_0000);

        // Error responses: unmapped, misaligned, and a write with no effect.
        apply_stimulus(1'b1, 1'b0, BASE | 32'h0000_0100, 32'd0);
        check_output("unmapped_err", err, 1'b1);
        apply_stimulus(1'b1, 1'b0, 32'h0200_0002, 32'd0);
        check_output("misalign_err", err, 1'b1);
        check_output("misalign_rd", rdata, 32'd0);
        apply_stimulus(1'b1, 1'b1, BASE | 32'h0000_8000, 32'hDEAD_BEEF);
        apply_stimulus(1'b1, 1'b1, BASE | 32'h0000_4001, 32'd0);
        apply_stimulus(1'b1, 1'b0, BASE | A_CMP_LO, 32'd0);

        // Hi read five cycles after a lo read, across a hi rollover.
        apply_stimulus(1'b1, 1'b1, BASE | A_TIME_LO, 32'hFFFF_FFFC);
        apply_stimulus(1'b1, 1'b1, BASE | A_TIME_HI, 32'd5);
        apply_stimulus(1'b1, 1'b0, BASE | A_TIME_LO, 32'd0);
        idle(4);
        apply_stimulus(1'b1, 1'b0, BASE | A_TIME_HI, 32'd0);
        check_output("snap_hi", rdata, SNAP_HI_EXP);

        // Randomized traffic with timer values kept near mtime.
        apply_stimulus(1'b1, 1'b1, BASE | A_CMP_HI, m_time[63:32]);
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 8);
            case (kind)
                0: pick = A_MSIP;
                1: pick = A_CMP_LO;
                2: pick = A_CMP_HI;
                3: pick = A_TIME_LO;
                4: pick = A_TIME_HI;
                5: pick = 16'h0100;
                6: pick = A_TIME_LO | 16'h0002;
                7: pick = 16'hBFF4;
                default: pick = A_CMP_LO;
            endcase
            ra = {16'($urandom_range(0, 3) == 0 ? $urandom : 32'h0200), pick};
            case (pick)
                A_MSIP:    rd = {$urandom, 1'b0} >> 1;
                A_CMP_LO:  rd = m_time[31:0] + 32'($urandom_range(0, 10)) - 32'd3;
                A_CMP_HI:  rd = m_time[63:32] + 32'($urandom_range(0, 1));
                A_TIME_LO: rd = m_cmp[31:0] - 32'($urandom_range(0, 6));
                A_TIME_HI: rd = m_time[63:32] + 32'($urandom_range(0, 2)) - 32'd1;
                default:   rd = $urandom;
            endcase
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, rd);
        end
        idle(2);

        // Reset asserted while an ack is pending: it is dropped for good.
        apply_stimulus(1'b1, 1'b0, BASE | A_MSIP, 32'd0);
        req = 1'b0;
        RST = 1'b1;
        #1;
        check_output("midrst_ack",  ack,         1'b0);
        check_output("midrst_tint", timer_int_m, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        idle(2);
        apply_stimulus(1'b1, 1'b0, BASE | A_CMP_LO, 32'd0);
        check_output("post_rst_cmp", rdata, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
